// File: rtl/md_pipe_share_arbiter.sv
// md_pipe_share_arbiter: round-robin share of one fixed-latency pipelined unit.
// Tags each issued operand with its requester ID and steers results back.
module md_pipe_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int ID_W    = 2,
  localparam int IFW    = $clog2(LATENCY + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       drain_req,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       unit_in_valid,
  output logic [WIDTH-1:0]           unit_in_data,
  input  logic [WIDTH-1:0]           unit_out_data,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_data,
  output logic [IFW-1:0]             in_flight,
  output logic                       busy,
  output logic                       drain_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               hs;
  logic               rsp;
  logic               uiv_q;
  logic [WIDTH-1:0]   uid_q;
  logic [ID_W-1:0]    uin_id_q;
  logic [LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];
  logic [IFW-1:0]     inflight_q, inflight_d;
  logic               idle_done_q;

  // First valid requester at or after rr_q, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == RUN) ? gnt : '0;
  assign hs        = (state_q == RUN) && gnt_any;
  assign rsp       = tag_v_q[LATENCY-1];

  always_comb begin
    rr_d = rr_q;
    if (hs) begin
      rr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  assign inflight_d = inflight_q + IFW'(hs) - IFW'(rsp);

  always_comb begin
    state_d    = state_q;
    drain_done = idle_done_q;
    unique case (state_q)
      IDLE:  if (!drain_req && enable) state_d = RUN;
      RUN:   if (drain_req || !enable) state_d = DRAIN;
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      uiv_q       <= 1'b0;
      uid_q       <= '0;
      uin_id_q    <= '0;
      tag_v_q     <= '0;
      inflight_q  <= '0;
      idle_done_q <= 1'b0;
      for (int s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      uiv_q       <= hs;
      inflight_q  <= inflight_d;
      idle_done_q <= (state_q == IDLE) && drain_req;
      if (hs) begin
        uid_q    <= req_data[int'(gnt_id)*WIDTH +: WIDTH];
        uin_id_q <= gnt_id;
      end
      // Tag stage LATENCY-1 lines up with unit_out_data
      tag_v_q[0]  <= uiv_q;
      tag_id_q[0] <= uin_id_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  assign unit_in_valid = uiv_q;
  assign unit_in_data  = uid_q;
  assign resp_valid    = rsp ? (NUM_REQ'(1) << tag_id_q[LATENCY-1]) : '0;
  assign resp_data     = unit_out_data;
  assign in_flight     = inflight_q;
  assign busy          = (state_q != IDLE) || (inflight_q != '0);

endmodule

// File: tb/tb_md_pipe_share_arbiter.sv
// tb_md_pipe_share_arbiter: scenario tasks plus random traffic
// checked against a queue-based model of grants and responses.
module tb_md_pipe_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int L  = 3;
  localparam int IW = 2;
  localparam int FW = $clog2(L + 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic drain_req = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           unit_in_valid;
  logic [W-1:0]   unit_in_data;
  logic [W-1:0]   unit_out_data;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic [FW-1:0]  in_flight;
  logic           busy;
  logic           drain_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_pipe_share_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .LATENCY(L), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .drain_req(drain_req),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .unit_in_valid(unit_in_valid), .unit_in_data(unit_in_data),
    .unit_out_data(unit_out_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .in_flight(in_flight), .busy(busy),
    .drain_done(drain_done)
  );

  // Shared unit stand-in: result = operand + 1, L cycles later
  logic [W-1:0] upipe [L];
  always_ff @(posedge clk) begin
    upipe[0] <= unit_in_data + 32'd1;
    for (int k = 1; k < L; k++) upipe[k] <= upipe[k-1];
  end
  assign unit_out_data = upipe[L-1];

  typedef struct {
    int           id;
    logic [W-1:0] val;
    int           due;
  } rsp_t;

  rsp_t         mq[$];
  int           m_state = 0;
  int           m_rr = 0;
  int           cyc = 0;
  bit           m_idone = 0;
  bit           m_uiv = 0;
  logic [W-1:0] m_uid = '0;
  int           m_last_gid = -1;

  logic [N-1:0] e_ready;
  logic [N-1:0] e_resp;
  logic [W-1:0] e_rdata;
  bit           e_done;
  bit           e_busy;
  int           e_if;
  int           e_gid;

  task automatic m_eval();
    e_ready = '0;
    e_gid   = -1;
    if (m_state == 1) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (e_gid < 0 && req_valid[i]) e_gid = i;
      end
    end
    if (e_gid >= 0) e_ready[e_gid] = 1'b1;
    e_resp  = '0;
    e_rdata = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      e_resp[mq[0].id] = 1'b1;
      e_rdata = mq[0].val;
    end
    e_if   = mq.size();
    e_busy = (m_state != 0) || (e_if != 0);
    e_done = m_idone || (m_state == 2 && e_if == 0);
  endtask

  task automatic m_commit();
    logic [W-1:0] op;
    if (mq.size() > 0 && mq[0].due == cyc) void'(mq.pop_front());
    m_uiv = (e_gid >= 0);
    m_last_gid = e_gid;
    if (e_gid >= 0) begin
      op = req_data[e_gid*W +: W];
      mq.push_back('{id: e_gid, val: op + 32'd1, due: cyc + 1 + L});
      m_uid = op;
      m_rr  = (e_gid + 1) % N;
    end
    m_idone = (m_state == 0) && drain_req;
    case (m_state)
      0: if (!drain_req && enable) m_state = 1;
      1: if (drain_req || !enable) m_state = 2;
      default: if (e_if == 0) m_state = 0;
    endcase
    cyc++;
  endtask

  task automatic m_reset();
    mq.delete();
    m_state = 0;
    m_rr = 0;
    m_idone = 0;
    m_uiv = 0;
    m_uid = '0;
    m_last_gid = -1;
  endtask

  task automatic advance();
    m_eval();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    total++; if (unit_in_valid !== 1'b0) begin bad++; $display("FAIL rst_uiv got=%b exp=0", unit_in_valid); end
    total++; if (unit_in_data !== '0) begin bad++; $display("FAIL rst_uid got=%h exp=0", unit_in_data); end
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL rst_resp got=%b exp=0", resp_valid); end
    total++; if (in_flight !== '0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", in_flight); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", drain_done); end
    @(posedge clk);
    #1;
    m_reset();
    rst = 1'b1;
  endtask

  task automatic test_single();
    enable = 1'b1;
    req_valid = '0;
    req_data[2*W +: W] = 32'hA5A5_0001;
    advance();
    req_valid = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL single_model_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (c == 0) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
      end
      if (c == 1) begin
        total++;
        if (unit_in_valid !== 1'b1 || unit_in_data !== 32'hA5A5_0001) begin
          bad++; $display("FAIL single_issue got=%b/%h exp=1/a5a50001", unit_in_valid, unit_in_data);
        end
      end
      if (c == 4) begin
        total++;
        if (resp_valid !== 4'b0100 || resp_data !== 32'hA5A5_0002) begin
          bad++; $display("FAIL single_resp got=%b/%h exp=0100/a5a50002", resp_valid, resp_data);
        end
      end else begin
        total++; if (resp_valid !== '0) begin bad++; $display("FAIL single_noresp c=%0d got=%b exp=0", c, resp_valid); end
      end
      advance();
      if (c == 0) req_valid = '0;
    end
  endtask

  task automatic test_all_four();
    int k = 0;
    int peak = 0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1000_0000 + i;
    req_valid = '1;
    advance();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rr_model_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (|req_ready) begin
        total++;
        if (req_ready !== (4'b0001 << (k % 4))) begin
          bad++; $display("FAIL rr_order k=%0d got=%b exp_id=%0d", k, req_ready, k % 4);
        end
        k++;
      end
      total++; if (resp_valid !== e_resp) begin bad++; $display("FAIL rr_resp c=%0d got=%b exp=%b", c, resp_valid, e_resp); end
      if (|e_resp) begin
        total++; if (resp_data !== e_rdata) begin bad++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, resp_data, e_rdata); end
      end
      if (c >= 1 && c <= 8) begin
        total++; if (unit_in_valid !== 1'b1) begin bad++; $display("FAIL rr_stream c=%0d got=%b exp=1", c, unit_in_valid); end
      end
      if (int'(in_flight) > peak) peak = int'(in_flight);
      advance();
      if (k == 8) req_valid = '0;
    end
    total++; if (k != 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", k); end
    total++; if (peak != L + 1) begin bad++; $display("FAIL rr_peak got=%0d exp=%0d", peak, L + 1); end
  endtask

  task automatic test_fairness();
    int k = 0;
    int exp_ids[4] = '{0, 3, 0, 3};
    req_valid = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL fair_model_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (|req_ready && k < 4) begin
        total++;
        if (req_ready !== (4'b0001 << exp_ids[k])) begin
          bad++; $display("FAIL fair_order k=%0d got=%b exp_id=%0d", k, req_ready, exp_ids[k]);
        end
        k++;
      end
      total++; if (resp_valid !== e_resp) begin bad++; $display("FAIL fair_resp c=%0d got=%b exp=%b", c, resp_valid, e_resp); end
      advance();
      if (k == 4) req_valid = '0;
    end
    total++; if (k != 4) begin bad++; $display("FAIL fair_count got=%0d exp=4", k); end
  endtask

  task automatic test_drain();
    int done_cnt = 0;
    int done_cyc = -1;
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL drain_model_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (c >= 4 && done_cyc < 0) begin
        total++; if (req_ready !== '0) begin bad++; $display("FAIL drain_noready c=%0d got=%b exp=0", c, req_ready); end
      end
      total++; if (resp_valid !== e_resp) begin bad++; $display("FAIL drain_resp c=%0d got=%b exp=%b", c, resp_valid, e_resp); end
      total++; if (drain_done !== e_done) begin bad++; $display("FAIL drain_done_model c=%0d got=%b exp=%b", c, drain_done, e_done); end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy c=%0d got=%b exp=0", c, busy); end
      end
      if (drain_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          total++; if (in_flight !== '0) begin bad++; $display("FAIL drain_inflight got=%0d exp=0", in_flight); end
        end
      end
      advance();
      if (c == 2) begin req_valid = '0; drain_req = 1'b1; end
      if (c == 3) begin req_valid = '1; drain_req = 1'b0; end
      if (c == done_cyc) req_valid = '0;
    end
    total++; if (done_cyc != 7) begin bad++; $display("FAIL drain_when got=%0d exp=7", done_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL drain_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_async_reset();
    req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL ar_model_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      advance();
    end
    total++; if (in_flight !== 3'd2) begin bad++; $display("FAIL ar_pre_inflight got=%0d exp=2", in_flight); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL ar_ready got=%b exp=0", req_ready); end
    total++; if (unit_in_valid !== 1'b0) begin bad++; $display("FAIL ar_uiv got=%b exp=0", unit_in_valid); end
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL ar_resp got=%b exp=0", resp_valid); end
    total++; if (in_flight !== '0) begin bad++; $display("FAIL ar_inflight got=%0d exp=0", in_flight); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    m_reset();
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk); m_eval();
      total++; if (resp_valid !== '0) begin bad++; $display("FAIL ar_ghost c=%0d got=%b exp=0", c, resp_valid); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL ar_busy_model c=%0d got=%b exp=%b", c, busy, e_busy); end
      advance();
    end
    req_valid = '1;
    @(negedge clk); m_eval();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ar_first_grant got=%b exp=0001", req_ready); end
    advance();
    req_valid = '0;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk); m_eval();
      total++; if (resp_valid !== e_resp) begin bad++; $display("FAIL ar_resp_model c=%0d got=%b exp=%b", c, resp_valid, e_resp); end
      advance();
    end
  endtask

  task automatic test_idle_drain();
    enable = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); m_eval();
      total++; if (drain_done !== e_done) begin bad++; $display("FAIL id_done_model c=%0d got=%b exp=%b", c, drain_done, e_done); end
      advance();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL id_idle_busy got=%b exp=0", busy); end
    enable = 1'b1;
    drain_req = 1'b1;
    req_valid = '1;
    @(negedge clk); m_eval();
    total++; if (req_ready !== '0) begin bad++; $display("FAIL id_ready0 got=%b exp=0", req_ready); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL id_done0 got=%b exp=0", drain_done); end
    advance();
    drain_req = 1'b0;
    @(negedge clk); m_eval();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL id_done1 got=%b exp=1", drain_done); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL id_ready1 got=%b exp=0", req_ready); end
    total++; if (unit_in_valid !== 1'b0) begin bad++; $display("FAIL id_nogrant got=%b exp=0", unit_in_valid); end
    advance();
    req_valid = '0;
    enable = 1'b0;
    for (int c = 0; c < 3; c++) advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_last_gid == i) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = $urandom;
        end
      end
      enable    = ($urandom_range(0, 9) != 0);
      drain_req = ($urandom_range(0, 19) == 0);
      @(negedge clk); m_eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      total++; if (resp_valid !== e_resp) begin bad++; $display("FAIL rnd_resp c=%0d got=%b exp=%b", c, resp_valid, e_resp); end
      if (|e_resp) begin
        total++; if (resp_data !== e_rdata) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, resp_data, e_rdata); end
      end
      total++; if (unit_in_valid !== m_uiv) begin bad++; $display("FAIL rnd_uiv c=%0d got=%b exp=%b", c, unit_in_valid, m_uiv); end
      total++; if (unit_in_data !== m_uid) begin bad++; $display("FAIL rnd_uid c=%0d got=%h exp=%h", c, unit_in_data, m_uid); end
      total++; if (int'(in_flight) != e_if) begin bad++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, in_flight, e_if); end
      total++; if (int'(in_flight) > L + 1) begin bad++; $display("FAIL rnd_inflight_bound c=%0d got=%0d max=%0d", c, in_flight, L + 1); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (drain_done !== e_done) begin bad++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, drain_done, e_done); end
      advance();
    end
    req_valid = '0;
    enable = 1'b0;
    drain_req = 1'b0;
    for (int c = 0; c < L + 4; c++) advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_drain();
    test_async_reset();
    test_idle_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_pipe_share_arbiter.md
Name: md_pipe_share_arbiter

Overview:
- Shares one fixed-latency, non-stallable pipelined datapath between NUM_REQ requesters, e.g. a long-range force/interpolation unit or a delay-matched arithmetic chain.
- Arbitrates round-robin, issues at most one operand per cycle, and tracks each in-flight operand's requester ID in a tag shift register matched to the unit latency.
- Steers each result back to the requester that issued it.
- Provides enable/drain sequencing so the long-range controller can quiesce the unit between mesh phases.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result data width.
- LATENCY, 3, fixed cycles from unit_in_* to the matching unit_out_data (>=1).
- ID_W, 2, requester-ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level; permits arbitration.
- drain_req  in  1  pulse; stop new grants and drain in-flight operands.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant (combinational).
- unit_in_valid  out  1  registered issue strobe to the shared unit.
- unit_in_data  out  WIDTH  registered operand to the shared unit.
- unit_out_data  in  WIDTH  unit result; valid exactly LATENCY cycles after the matching unit_in_valid.
- resp_valid  out  NUM_REQ  one-hot result strobe.
- resp_data  out  WIDTH  result, equal to unit_out_data.
- in_flight  out  clog2(LATENCY+2)  operands granted but not yet returned.
- busy  out  1  state != IDLE or in_flight != 0.
- drain_done  out  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = IDLE, rr_ptr = 0, in_flight = 0, all tag valids = 0;
  - unit_in_valid = 0, unit_in_data = 0, drain_done = 0, hence req_ready = 0, resp_valid = 0, busy = 0.
  - Operands already inside the unit at reset are discarded; no resp_valid is generated for them after rst is released.
- State machine:
  - IDLE -> RUN when enable = 1 and drain_req = 0.
  - RUN -> DRAIN on drain_req = 1, or when enable = 0.
  - DRAIN -> IDLE in the cycle in_flight = 0, with no grant possible; drain_done pulses for one cycle on that transition.
  - drain_req in IDLE: drain_done pulses on the next cycle and the state stays IDLE.
  - drain_req has priority over enable in the same cycle.
- Arbitration (RUN only):
  - Search for a requester starting at rr_ptr and wrapping modulo NUM_REQ.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1; at most one bit is set.
  - Handshake = req_valid[i] & req_ready[i], in cycle t.
  - After a handshake, rr_ptr = (i+1) mod NUM_REQ; with no handshake, rr_ptr holds.
  - req_ready is all zeros in IDLE and DRAIN.
  - Requesters must hold req_data stable while req_valid is high.
- Issue: a handshake in cycle t gives unit_in_valid = 1 and unit_in_data = req_data[i] in cycle t+1. Otherwise unit_in_valid = 0 and unit_in_data holds its last value.
- Tag pipe:
  - LATENCY stages of {valid, ID}.
  - Stage 0 loads {unit_in_valid, granted ID} alongside unit_in_*.
  - The final stage is aligned with unit_out_data.
- Response:
  - In cycle t+1+LATENCY, resp_valid[ID] = 1 (combinational decode of the final tag stage) and resp_data = unit_out_data.
  - Responses cannot be back-pressured.
  - Back-to-back grants give back-to-back responses, in issue order.
- in_flight:
  - +1 on a handshake, -1 on a resp_valid; unchanged when both occur in the same cycle.
  - Maximum value is LATENCY+1. It never under- or over-flows; the bench asserts this.

Test Plan:
- Single requester: rst high, enable = 1, req_valid = 4'b0100, data 0xA5A5_0001 at t.
  - req_ready[2] = 1 at t; unit_in_valid = 1 with 0xA5A5_0001 at t+1.
  - Unit model adds 1: resp_valid = 4'b0100 and resp_data = 0xA5A5_0002 at t+4 (LATENCY = 3).
- All four requesters held valid for 8 cycles from rr_ptr = 0.
  - Grant order 0,1,2,3,0,1,2,3; one unit_in_valid every cycle.
  - Responses return IDs in the same order; in_flight peaks at 4 (LATENCY+1).
- Fairness: req 0 and req 3 valid continuously, last grant was to 3.
  - Grants alternate 0,3,0,3; rr_ptr skips idle requesters 1 and 2.
- Drain: 3 operands in flight, then drain_req pulse.
  - req_ready = 0 from the next cycle onward.
  - Remaining 3 responses are delivered, then drain_done pulses once with in_flight = 0; busy falls the cycle after.
- Async reset mid-operation: rst low with 2 operands in flight.
  - Outputs clear immediately, with no clock edge needed; no resp_valid appears after rst returns high.
  - in_flight = 0; the first grant after re-enable goes to requester 0.
- Simultaneous enable and drain_req in IDLE: stays IDLE and drain_done pulses one cycle later; no grant is issued.
